// File: rtl/mux8_rr_scheduler.sv
// mux8_rr_scheduler: round-robin scheduler sharing one 8:1 mux output among 8 requesters
module mux8_rr_scheduler #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          req,
    input  logic [8*DATA_W-1:0] in_data,
    input  logic                out_ready,
    output logic [7:0]          gnt,
    output logic                s2,
    output logic                s1,
    output logic                s0,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic                busy
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t      state;
    logic [2:0]  ptr, sel, winner;
    logic [3:0]  beat_cnt;
    logic        accept, done;
    // Descending scan so the lowest offset from ptr wins.
    always_comb begin
        winner = ptr;
        for (int k = 7; k >= 0; k--)
            if (req[ptr + 3'(k)]) winner = ptr + 3'(k);
    end
    assign busy         = state == GRANT;
    assign gnt          = busy ? 8'd1 << sel : 8'd0;
    assign {s2, s1, s0} = sel;
    assign out_valid    = busy & req[sel];
    assign out_data     = in_data[sel*DATA_W +: DATA_W];
    assign accept       = out_valid & out_ready;
    assign done         = !req[sel] | (accept & beat_cnt == 4'(MAX_BURST - 1));
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            sel      <= '0;
            beat_cnt <= '0;
        end else if (state == IDLE) begin
            if (|req) begin
                sel      <= winner;
                beat_cnt <= '0;
                state    <= GRANT;
            end
        end else if (done) begin
            ptr   <= sel + 3'd1;
            state <= IDLE;
        end else if (accept) begin
            beat_cnt <= beat_cnt + 4'd1;
        end
    end
endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// tb_mux8_rr_scheduler: randomized bench against a behavioural round-robin model
module tb_mux8_rr_scheduler;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;

    logic                clk = 0;
    logic                rst;
    logic [7:0]          req;
    logic [8*DATA_W-1:0] in_data;
    logic                out_ready;
    logic [7:0]          gnt;
    logic                s2, s1, s0;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic                busy;

    int tests = 0;
    int fails = 0;
    bit armed = 0;

    int owner = -1;
    int next_ptr = 0;
    int last_sel = 0;
    int beats = 0;

    mux8_rr_scheduler #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst), .req(req), .in_data(in_data), .out_ready(out_ready),
        .gnt(gnt), .s2(s2), .s1(s1), .s0(s0), .out_valid(out_valid),
        .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference: who owns the channel, where the next search starts, beats taken so far.
    always @(posedge clk) begin
        if (rst) begin
            owner = -1; next_ptr = 0; last_sel = 0; beats = 0;
        end else if (owner < 0) begin
            for (int k = 0; k < 8; k++)
                if (owner < 0 && req[(next_ptr + k) % 8]) owner = (next_ptr + k) % 8;
            if (owner >= 0) begin last_sel = owner; beats = 0; end
        end else if (!req[owner]) begin
            next_ptr = (owner + 1) % 8; owner = -1;
        end else if (out_ready) begin
            beats++;
            if (beats == MAX_BURST) begin next_ptr = (owner + 1) % 8; owner = -1; end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("gnt", 32'(gnt), owner >= 0 ? 32'(1) << owner : 32'd0);
            chk("sel", 32'({s2, s1, s0}), 32'(last_sel));
            chk("busy", 32'(busy), 32'(owner >= 0));
            chk("out_valid", 32'(out_valid), 32'(owner >= 0 && req[owner]));
            chk("out_data", 32'(out_data), 32'(in_data[last_sel*DATA_W +: DATA_W]));
        end
    end

    task automatic cyc(int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        logic [DATA_W-1:0] held;
        rst = 1; req = '0; out_ready = 0; in_data = '0;
        cyc(2);
        armed = 1;
        @(negedge clk);
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_valid", 32'(out_valid), 32'h0);

        // Single requester on lane 2, one-cycle grant latency.
        rst = 0; req = 8'h04; out_ready = 1; in_data[2*DATA_W +: DATA_W] = 8'hA5;
        cyc();
        @(negedge clk);
        chk("t1_gnt", 32'(gnt), 32'h04);
        chk("t1_sel", 32'({s2, s1, s0}), 32'h2);
        chk("t1_valid", 32'(out_valid), 32'h1);
        chk("t1_data", 32'(out_data), 32'hA5);
        cyc(8);
        req = '0;
        cyc(2);

        // Everyone requesting: full rotation with bursts and bubbles.
        req = 8'hFF;
        cyc(45);
        req = '0;
        cyc(2);

        // Stalled downstream holds the grant on 3.
        rst = 1; cyc(); rst = 0;
        req = 8'h08; out_ready = 0; in_data[3*DATA_W +: DATA_W] = 8'h3C;
        cyc();
        held = out_data;
        cyc(4);
        @(negedge clk);
        chk("t4_gnt_held", 32'(gnt), 32'h08);
        chk("t4_data_held", 32'(out_data), 32'(held));
        out_ready = 1;
        cyc(6);
        req = '0;
        cyc(2);

        // Reset mid-burst on requester 4; search restarts at 0.
        req = 8'h30; out_ready = 1;
        cyc(2);
        rst = 1;
        cyc();
        @(negedge clk);
        chk("t6_gnt_rst", 32'(gnt), 32'h0);
        chk("t6_busy_rst", 32'(busy), 32'h0);
        rst = 0;
        cyc();
        @(negedge clk);
        chk("t6_regrant", 32'(gnt), 32'h10);
        req = '0;
        cyc(2);

        // Randomized traffic with withdrawals, stalls and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 8; i++)
                if ($urandom_range(7) == 0) req[i] = ~req[i];
            out_ready = $urandom_range(3) != 0;
            rst = $urandom_range(299) == 0;
            for (int i = 0; i < 8; i++) in_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
            cyc();
        end
        rst = 0; req = '0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
